// File: rtl/pipe_reg_stage.sv
// Parametrised inter-stage pipeline register: DEPTH collapsing slots with valid/ready, stall and flush.
// Optional one-entry input skid buffer when PIPE_REG_STAGE_SKID_EN is defined.
module pipe_reg_stage #(
    parameter int                 WIDTH       = 8,
    parameter int                 DEPTH       = 1,
    parameter logic [WIDTH-1:0]   BUBBLE_DATA = '0
) (
    input  logic                         clk,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         stall,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+2)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 2);

    logic                 run;
    logic                 in_fire;
    logic                 skid_valid;
    logic [DEPTH-1:0]     v_vec;
    logic [WIDTH-1:0]     d_arr [DEPTH];
    logic [DEPTH-1:0]     load;
    logic [DEPTH-1:0]     src_v;
    logic [WIDTH-1:0]     src_d [DEPTH];
    logic [OCC_W-1:0]     occ_sum;

    assign run = !stall && !flush && !start;

    // A slot can take its source when empty or when the slot ahead is taking it this cycle.
    always_comb begin
        logic chain;
        load  = '0;
        chain = !v_vec[DEPTH-1] || out_ready;
        load[DEPTH-1] = chain;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            chain   = !v_vec[i] || chain;
            load[i] = chain;
        end
    end

`ifdef PIPE_REG_STAGE_SKID_EN
    logic             skid_v_reg;
    logic [WIDTH-1:0] skid_d_reg;

    // Ready comes only from the skid flop (start gates it so nothing lands during reset).
    assign in_ready   = !skid_v_reg && !start;
    assign in_fire    = in_valid && in_ready;
    assign skid_valid = skid_v_reg;
    assign src_v[0]   = skid_v_reg || in_fire;
    assign src_d[0]   = skid_v_reg ? skid_d_reg : in_data;

    always_ff @(posedge clk) begin
        if (start || flush) begin
            skid_v_reg <= 1'b0;
            skid_d_reg <= BUBBLE_DATA;
        end else if (!stall && load[0]) begin
            skid_v_reg <= 1'b0;
        end else if (in_fire) begin
            skid_v_reg <= 1'b1;
            skid_d_reg <= in_data;
        end
    end
`else
    assign in_ready   = run && load[0];
    assign in_fire    = in_valid && in_ready;
    assign skid_valid = 1'b0;
    assign src_v[0]   = in_fire;
    assign src_d[0]   = in_data;
`endif

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic             v_reg;
            logic [WIDTH-1:0] d_reg;

            if (gi > 0) begin : g_src
                assign src_v[gi] = v_vec[gi-1];
                assign src_d[gi] = d_arr[gi-1];
            end

            // Payload is only overwritten by a valid source, so out_data holds the last beat.
            always_ff @(posedge clk) begin
                if (start || flush) begin
                    v_reg <= 1'b0;
                    d_reg <= BUBBLE_DATA;
                end else if (!stall && load[gi]) begin
                    v_reg <= src_v[gi];
                    if (src_v[gi]) begin
                        d_reg <= src_d[gi];
                    end
                end
            end

            assign v_vec[gi] = v_reg;
            assign d_arr[gi] = d_reg;
        end
    endgenerate

    always_comb begin
        occ_sum = {{(OCC_W-1){1'b0}}, skid_valid};
        for (int i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + {{(OCC_W-1){1'b0}}, v_vec[i]};
        end
    end

    assign out_valid = v_vec[DEPTH-1] && run;
    assign out_data  = d_arr[DEPTH-1];
    assign occupancy = occ_sum;

endmodule

// File: tb/tb_pipe_reg_stage.sv
// Scoreboard bench for pipe_reg_stage (WIDTH=8, DEPTH=3, BUBBLE_DATA=FF) with a beat-position reference model.
module tb_pipe_reg_stage;

    localparam int         WIDTH  = 8;
    localparam int         DEPTH  = 3;
    localparam logic [7:0] BUBBLE = 8'hFF;

    logic             clk = 1'b0;
    logic             start, in_valid, stall, flush, out_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       occupancy;

    pipe_reg_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BUBBLE_DATA(BUBBLE)) dut (
        .clk(clk), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .stall(stall), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each held beat has a position (-1 = skid, 0..DEPTH-1 = slot), oldest first.
    typedef struct {
        int         pos;
        logic [7:0] data;
    } beat_t;

    beat_t      pipe_q[$];
    beat_t      nxt_q[$];
    logic [7:0] sb_q[$];
    logic [7:0] last_data;
    bit         model_on = 0;

    always @(negedge clk) begin
        bit    run, out_go, slot0_free, exp_ir, exp_ov, in_go;
        int    lim, np;
        beat_t b;
        if (start) begin
            if (model_on) begin
                chk("start_in_ready", in_ready, 0);
                chk("start_out_valid", out_valid, 0);
            end
            pipe_q.delete();
            sb_q.delete();
            last_data = BUBBLE;
            model_on  = 1;
        end else if (model_on) begin
            run    = !stall && !flush;
            exp_ov = run && pipe_q.size() > 0 && pipe_q[0].pos == DEPTH - 1;
            chk("out_valid", out_valid, exp_ov);
            chk("occupancy", occupancy, pipe_q.size());
            chk("out_data_hold", out_data, last_data);
            out_go = exp_ov && out_ready;
            nxt_q.delete();
            if (run) begin
                lim = DEPTH - 1;
                foreach (pipe_q[k]) begin
                    b = pipe_q[k];
                    if (k == 0 && out_go) continue;
                    np = (b.pos + 1 < lim) ? b.pos + 1 : lim;
                    if (np == DEPTH - 1 && b.pos != DEPTH - 1) last_data = b.data;
                    b.pos = np;
                    nxt_q.push_back(b);
                    lim = np - 1;
                end
            end else if (!flush) begin
                nxt_q = pipe_q;
            end
            slot0_free = (nxt_q.size() == 0) || (nxt_q[$].pos > 0);
`ifdef PIPE_REG_STAGE_SKID_EN
            exp_ir = !(pipe_q.size() > 0 && pipe_q[$].pos == -1);
`else
            exp_ir = run && slot0_free;
`endif
            chk("in_ready", in_ready, exp_ir);
            in_go = in_valid && exp_ir;
            if (flush) begin
                nxt_q.delete();
                sb_q.delete();
                last_data = BUBBLE;
            end else if (in_go) begin
                b.pos  = (run && slot0_free) ? 0 : -1;
                b.data = in_data;
                nxt_q.push_back(b);
                sb_q.push_back(in_data);
                $display("in  data=%02h held=%0d", in_data, nxt_q.size());
            end
            pipe_q = nxt_q;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT hands a beat downstream.
    always @(negedge clk) begin
        logic [7:0] exp_d;
        if (model_on && !start && out_valid && out_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected actual=%02h required=none at %0t", out_data, $time);
            end else begin
                exp_d = sb_q.pop_front();
                if (out_data !== exp_d) begin
                    bad++;
                    $display("FAIL out_beat actual=%02h required=%02h at %0t", out_data, exp_d, $time);
                end else begin
                    $display("out data=%02h", out_data);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic offer(input logic [7:0] dv, input int max_cyc, output bit acc);
        acc      = 0;
        in_valid = 1;
        in_data  = dv;
        for (int c = 0; c < max_cyc && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
    endtask

    initial begin
        bit acc;
        start = 1; in_valid = 1; in_data = 8'h55; stall = 0; flush = 0; out_ready = 0;
        cyc(3);
        start = 0; in_valid = 0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, BUBBLE);
        chk("reset_occ", occupancy, 0);
        chk("reset_in_ready", in_ready, 1);
        cyc(1);

        // Streaming 01..0A back-to-back
        out_ready = 1;
        for (int i = 1; i <= 10; i++) begin
            offer(8'(i), 5, acc);
            chk("stream_accept", acc, 1);
        end
        cyc(6);

        // Backpressure
        out_ready = 0;
        offer(8'hA1, 5, acc); chk("bp_a1", acc, 1);
        offer(8'hA2, 5, acc); chk("bp_a2", acc, 1);
        offer(8'hA3, 5, acc); chk("bp_a3", acc, 1);
        cyc(3);
        offer(8'hA4, 4, acc);
`ifdef PIPE_REG_STAGE_SKID_EN
        chk("bp_a4_skid", acc, 1);
`else
        chk("bp_a4_refused", acc, 0);
`endif
        out_ready = 1;
        cyc(8);

        // Stall holding 10, 20
        out_ready = 0;
        offer(8'h10, 5, acc); chk("stall_fill10", acc, 1);
        offer(8'h20, 5, acc); chk("stall_fill20", acc, 1);
        cyc(3);
        out_ready = 1; stall = 1;
        cyc(4);
        stall = 0;
        cyc(6);

        // Flush together with stall while 3 beats are held
        out_ready = 0;
        offer(8'h31, 5, acc);
        offer(8'h32, 5, acc);
        offer(8'h33, 5, acc);
        cyc(3);
        flush = 1; stall = 1; in_valid = 1; in_data = 8'h99;
        cyc(1);
        flush = 0; stall = 0; in_valid = 0;
        @(negedge clk);
        chk("flush_occ", occupancy, 0);
        chk("flush_out_data", out_data, BUBBLE);
        cyc(2);

        // Bubble collapse: alternating beats, blocked output
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            offer(8'hC0 + 8'(i), 5, acc);
            chk("bubble_accept", acc, 1);
            cyc(1);
        end
        cyc(2);
        @(negedge clk);
        chk("bubble_packed_occ", occupancy, 3);
        cyc(1);
        out_ready = 1;
        cyc(6);

        // Randomized traffic
        for (int c = 0; c < 1000; c++) begin
            in_valid  = ($urandom % 3) != 0;
            in_data   = 8'($urandom);
            out_ready = ($urandom % 4) != 0;
            stall     = ($urandom % 10) == 0;
            flush     = ($urandom % 40) == 0;
            start     = ($urandom % 150) == 0;
            cyc(1);
        end
        in_valid = 0; stall = 0; flush = 0; start = 0; out_ready = 1;
        cyc(12);
        chk("drain_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_reg_stage.md
# pipe_reg_stage

Parametrised pipeline register for the processor datapath, the successor to the fixed per-boundary latches between fetch, decode, execute, memory and write-back. It carries a WIDTH-bit payload through DEPTH register slots with a valid bit per slot, a valid/ready handshake on both sides, global stall, and flush with bubble insertion. Empty slots collapse, so bubbles never block younger beats. One instance replaces any single inter-stage latch; DEPTH>1 builds multi-cycle execute or memory paths.

## Interface
- WIDTH, 8: payload width in bits (≥1).
- DEPTH, 1: number of register slots (≥1).
- BUBBLE_DATA, 0: payload value loaded into a slot on reset or flush.
- clk  in  1  clock; all state updates on the rising edge.
- start  in  1  synchronous active-high reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  WIDTH  upstream payload.
- stall  in  1  freeze all slots (hazard unit).
- flush  in  1  kill all in-flight beats (taken branch / halt).
- out_valid  out  1  beat available downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload of the last slot.
- occupancy  out  $clog2(DEPTH+2)  valid entries held, skid included.

## Operation
- Slots 0..DEPTH-1; slot 0 is nearest the input. Each slot holds v[i] and d[i].
- Transfer out: out_valid && out_ready. Transfer in: in_valid && in_ready.
- out_valid = v[DEPTH-1] && !stall && !flush. out_data = d[DEPTH-1] at all times.
- Slot advance (stall=0, flush=0): slot i loads from slot i-1 (or the input for i=0) when v[i]=0 or slot i empties this cycle; the last slot empties on a transfer out. A slot whose source is empty becomes invalid; d[i] is left unchanged.
- stall=1, flush=0: no slot changes; no transfer out. Input behaviour depends on configuration.
- flush=1: every v[i] (and the skid entry) clears next edge; d[i] loads BUBBLE_DATA. No transfer in or out in the flush cycle; flush overrides stall.
- start=1: same effect as flush, and occupancy=0. Overrides all other inputs. A reset mid-stream discards all held beats.
- occupancy = popcount(v) + skid valid. It updates one cycle after the event.
- Simultaneous transfer in and out with the pipe full: permitted, and occupancy stays the same.
- Beat order is preserved. Beats are never duplicated or dropped, except by flush or start.

## Timing
- Reset values, held for the cycle after start: out_valid=0, out_data=BUBBLE_DATA, occupancy=0. in_ready=1 (0 while start is held).
- Latency: a beat accepted at edge N is visible on out_data/out_valid after edge N+DEPTH-1, when unblocked.
- Throughput: one beat per cycle sustained with out_ready=1 and stall=0.
- in_ready without skid: combinational. in_ready = !stall && !flush && !start && (v[0]=0 || slot 0 advances this cycle).
- Flush or start asserted at edge N: out_valid=0 during cycle N and after edge N. in_ready is 0 during cycle N and returns to 1 after edge N.

## Configuration
- PIPE_REG_STAGE_SKID_EN defined:
  - Adds a one-entry skid buffer ahead of slot 0.
  - in_ready = skid empty, driven straight from a flop, with no combinational path from stall, out_ready or flush.
  - A beat accepted while slot 0 cannot advance, or during stall, goes into the skid.
  - The skid drains into slot 0 before new input.
  - Flush and start clear the skid.
  - occupancy maximum is DEPTH+1.
- Undefined: no skid entry. in_ready is combinational as above, and occupancy maximum is DEPTH.

## Test plan
- Reset: WIDTH=8, DEPTH=3, BUBBLE_DATA=8'hFF. Hold start for 2 cycles with in_valid=1 → out_valid=0, out_data=8'hFF and occupancy=0 after release.
- Streaming: DEPTH=3, feed 8'h01..8'h0A on consecutive cycles with out_ready=1 → first out_valid 2 cycles after the first accept, then 10 consecutive beats in order, with occupancy steady at 3.
- Backpressure: DEPTH=2, out_ready=0 after accepting 8'hA1, 8'hA2, 8'hA3 → without skid, in_ready drops once occupancy=2. With PIPE_REG_STAGE_SKID_EN, 8'hA3 is accepted into the skid and occupancy=3. Releasing out_ready delivers A1, A2 (and A3) in order.
- Stall: hold stall for 4 cycles with the pipe holding 8'h10, 8'h20 → out_valid=0 and slot contents unchanged during the stall, then 8'h10, 8'h20 are delivered after stall drops.
- Flush with stall: assert flush and stall together while 3 beats are held → occupancy=0 and out_valid=0 next cycle, out_data=BUBBLE_DATA, and the flush-cycle input is not accepted.
- Bubble collapse: DEPTH=3, beats on alternating cycles with out_ready=0, then release → beats pack into adjacent slots (occupancy=3 after 3 accepts) and drain back-to-back.
